// File: rtl/window3x3_if.sv
// Pixel stream in / 3x3 window stream out for window3x3_gen.
// master drives pixels and observes windows; slave is the generator side.
interface window3x3_if #(
  parameter int CNT_W = 10
);
  logic             in_valid;
  logic             in_sof;
  logic [7:0]       in_pixel;
  logic             out_valid;
  logic [7:0]       a1, a2, a3, a4, a5, a6, a7, a8, a9;
  logic [CNT_W-1:0] out_row;
  logic [CNT_W-1:0] out_col;

  modport master (
    output in_valid, in_sof, in_pixel,
    input  out_valid, a1, a2, a3, a4, a5, a6, a7, a8, a9, out_row, out_col
  );

  modport slave (
    input  in_valid, in_sof, in_pixel,
    output out_valid, a1, a2, a3, a4, a5, a6, a7, a8, a9, out_row, out_col
  );
endinterface

// File: rtl/window3x3_gen.sv
// Streaming 3x3 window generator with two line buffers; emits interior windows only.
// Optional macro WIN3X3_OUT_PIPE_EN adds a second output register stage (latency 2).
//   state | meaning
//   IDLE  | after reset, waiting for an accept with in_sof
//   FILL  | rows 0..1 of a frame are being buffered, no output
//   RUN   | row >= 2, windows emitted for columns >= 2
module window3x3_gen #(
  parameter int IMG_WIDTH  = 850,
  parameter int IMG_HEIGHT = 850,
  parameter int CNT_W      = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  window3x3_if.slave   bus
);
  localparam int               AW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_HEIGHT - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] col_q, col_d, row_q, row_d;
  logic [CNT_W-1:0] col_cur, row_cur;
  logic [8:0][7:0]  win_q, win_d;
  logic [8:0][7:0]  owin_q, owin_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] out_row_q, out_row_d, out_col_q, out_col_d;
  logic [7:0]       lb0_q [IMG_WIDTH];
  logic [7:0]       lb1_q [IMG_WIDTH];
  logic             accept, sof, emit;
  logic [AW-1:0]    lb_idx;
  logic [7:0]       lb0_rd, lb1_rd;
  logic [8:0][7:0]  win_o;
  logic             valid_o;
  logic [CNT_W-1:0] row_o, col_o;

  always_comb begin
    sof         = bus.in_valid && bus.in_sof;
    accept      = bus.in_valid && ((state_q != IDLE) || bus.in_sof);
    col_cur     = sof ? '0 : col_q;
    row_cur     = sof ? '0 : row_q;
    lb_idx      = col_cur[AW-1:0];
    lb0_rd      = lb0_q[lb_idx];
    lb1_rd      = lb1_q[lb_idx];
    emit        = accept && !sof && (state_q == RUN) && (col_cur >= TWO);
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    win_d       = win_q;
    out_valid_d = emit;
    owin_d      = owin_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    if (accept) begin
      // index 0 is a1, index 8 is a9; the new right column is {lb1, lb0, pixel}
      win_d = {bus.in_pixel, win_q[8], win_q[7],
               lb0_rd,       win_q[5], win_q[4],
               lb1_rd,       win_q[2], win_q[1]};
      if (col_cur == COL_LAST) begin
        col_d = '0;
        row_d = (row_cur == ROW_LAST) ? '0 : row_cur + ONE;
      end else begin
        col_d = col_cur + ONE;
        row_d = row_cur;
      end
      state_d = (row_d >= TWO) ? RUN : FILL;
    end
    if (emit) begin
      owin_d    = win_d;
      out_row_d = row_cur - ONE;
      out_col_d = col_cur - ONE;
    end
  end

  // Line buffer contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[lb_idx] <= lb0_rd;
      lb0_q[lb_idx] <= bus.in_pixel;
    end
  end

`ifdef WIN3X3_OUT_PIPE_EN
  logic             pipe_valid_q;
  logic [8:0][7:0]  pipe_win_q;
  logic [CNT_W-1:0] pipe_row_q, pipe_col_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid_q <= 1'b0;
      pipe_win_q   <= '0;
      pipe_row_q   <= '0;
      pipe_col_q   <= '0;
    end else begin
      pipe_valid_q <= out_valid_q;
      pipe_win_q   <= owin_q;
      pipe_row_q   <= out_row_q;
      pipe_col_q   <= out_col_q;
    end
  end

  assign valid_o = pipe_valid_q;
  assign win_o   = pipe_win_q;
  assign row_o   = pipe_row_q;
  assign col_o   = pipe_col_q;
`else
  assign valid_o = out_valid_q;
  assign win_o   = owin_q;
  assign row_o   = out_row_q;
  assign col_o   = out_col_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      owin_q      <= '0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      owin_q      <= owin_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
    end
  end

  assign bus.out_valid = valid_o;
  assign bus.out_row   = row_o;
  assign bus.out_col   = col_o;
  assign bus.a1        = win_o[0];
  assign bus.a2        = win_o[1];
  assign bus.a3        = win_o[2];
  assign bus.a4        = win_o[3];
  assign bus.a5        = win_o[4];
  assign bus.a6        = win_o[5];
  assign bus.a7        = win_o[6];
  assign bus.a8        = win_o[7];
  assign bus.a9        = win_o[8];
endmodule
